// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and stall sequencer for the 5-stage pipeline: stall, bubble, flush
// and forwarding controls, plus saturating stall/flush counters and a timeout flag.
//
//   state    | meaning
//   RUN      | pipe flowing; memory wait, branch flush and load-use detected here
//   MEM_WAIT | data-memory access outstanding; pipe frozen until dmem_ready
//   FLUSH    | extra IF/ID flush cycles after a taken branch

module pipeline_hazard_ctrl #(
  parameter int unsigned FLUSH_LEN   = 1,
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_rf_wr_en,
  input  logic             ex_is_load,
  input  logic [4:0]       ex_rs1,
  input  logic [4:0]       ex_rs2,
  input  logic             ex_branch_taken,
  input  logic [4:0]       mem_rd,
  input  logic [4:0]       wb_rd,
  input  logic             mem_rf_wr_en,
  input  logic             wb_rf_wr_en,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             exmem_stall,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             timeout_err
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    FLUSH    = 2'b10
  } state_e;

  localparam int unsigned       WAIT_W      = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX    = WAIT_W'(MEM_TIMEOUT);
  localparam logic [2:0]        FLUSH_EXTRA = 3'(FLUSH_LEN - 1);

  state_e             state_q, state_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [2:0]         flush_q, flush_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;
  logic               timeout_q, timeout_d;

  logic mem_wait, load_use, branch_acc;
  logic pc_stall_c, ifid_stall_c, ifid_flush_c, idex_bubble_c, exmem_stall_c;

  assign mem_wait = dmem_req & ~dmem_ready;
  assign load_use = ex_is_load & ex_rf_wr_en & (ex_rd != 5'd0) &
                    ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));

  always_comb begin
    state_d       = state_q;
    wait_d        = wait_q;
    flush_d       = flush_q;
    timeout_d     = timeout_q;
    pc_stall_c    = 1'b0;
    ifid_stall_c  = 1'b0;
    ifid_flush_c  = 1'b0;
    idex_bubble_c = 1'b0;
    exmem_stall_c = 1'b0;
    branch_acc    = 1'b0;
    case (state_q)
      RUN: begin
        if (mem_wait) begin
          pc_stall_c    = 1'b1;
          ifid_stall_c  = 1'b1;
          exmem_stall_c = 1'b1;
          state_d       = MEM_WAIT;
          wait_d        = '0;
        end else if (ex_branch_taken) begin
          ifid_flush_c  = 1'b1;
          idex_bubble_c = 1'b1;
          branch_acc    = 1'b1;
          if (FLUSH_LEN > 1) begin
            state_d = FLUSH;
            flush_d = FLUSH_EXTRA;
          end
        end else if (load_use) begin
          pc_stall_c    = 1'b1;
          ifid_stall_c  = 1'b1;
          idex_bubble_c = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (!dmem_ready) begin
          pc_stall_c    = 1'b1;
          ifid_stall_c  = 1'b1;
          exmem_stall_c = 1'b1;
          if (wait_q != WAIT_MAX) wait_d = wait_q + WAIT_W'(1);
          if (wait_d == WAIT_MAX) timeout_d = 1'b1;
        end else begin
          state_d = RUN;
          wait_d  = '0;
        end
      end
      FLUSH: begin
        // A memory wait here freezes the pipe; the remaining flush cycles resume afterwards.
        if (mem_wait) begin
          pc_stall_c    = 1'b1;
          ifid_stall_c  = 1'b1;
          exmem_stall_c = 1'b1;
        end else begin
          ifid_flush_c = 1'b1;
          if (flush_q <= 3'd1) begin
            state_d = RUN;
            flush_d = '0;
          end else begin
            flush_d = flush_q - 3'd1;
          end
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (pc_stall_c && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (branch_acc && !(&flush_cnt_q)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= RUN;
      wait_q      <= '0;
      flush_q     <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      flush_q     <= flush_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
    if (mem_rf_wr_en && (mem_rd != 5'd0) && (mem_rd == rs)) return 2'b01;
    if (wb_rf_wr_en && (wb_rd != 5'd0) && (wb_rd == rs))    return 2'b10;
    return 2'b00;
  endfunction

  // Combinational controls are forced low while reset is held.
  assign pc_stall    = pc_stall_c & reset;
  assign ifid_stall  = ifid_stall_c & reset;
  assign ifid_flush  = ifid_flush_c & reset;
  assign idex_bubble = idex_bubble_c & reset;
  assign exmem_stall = exmem_stall_c & reset;
  assign fwd_a       = reset ? fwd_sel(ex_rs1) : 2'b00;
  assign fwd_b       = reset ? fwd_sel(ex_rs2) : 2'b00;
  assign state       = state_q;
  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;
  assign timeout_err = timeout_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: fixed vectors, directed
// multi-cycle sequences and randomized traffic against a behavioural model.

module tb_pipeline_hazard_ctrl;

  localparam int FLUSH_LEN   = 2;
  localparam int MEM_TIMEOUT = 15;
  localparam int CNT_W       = 4;
  localparam int CNT_MAX     = 15;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [4:0]       id_rs1, id_rs2, ex_rd, ex_rs1, ex_rs2, mem_rd, wb_rd;
  logic             id_use_rs1, id_use_rs2, ex_rf_wr_en, ex_is_load, ex_branch_taken;
  logic             mem_rf_wr_en, wb_rf_wr_en, dmem_req, dmem_ready;
  logic             pc_stall, ifid_stall, ifid_flush, idex_bubble, exmem_stall;
  logic [1:0]       fwd_a, fwd_b, state;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic             timeout_err;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(
    .FLUSH_LEN  (FLUSH_LEN),
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .CNT_W      (CNT_W)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .id_rs1         (id_rs1),
    .id_rs2         (id_rs2),
    .id_use_rs1     (id_use_rs1),
    .id_use_rs2     (id_use_rs2),
    .ex_rd          (ex_rd),
    .ex_rf_wr_en    (ex_rf_wr_en),
    .ex_is_load     (ex_is_load),
    .ex_rs1         (ex_rs1),
    .ex_rs2         (ex_rs2),
    .ex_branch_taken(ex_branch_taken),
    .mem_rd         (mem_rd),
    .wb_rd          (wb_rd),
    .mem_rf_wr_en   (mem_rf_wr_en),
    .wb_rf_wr_en    (wb_rf_wr_en),
    .dmem_req       (dmem_req),
    .dmem_ready     (dmem_ready),
    .pc_stall       (pc_stall),
    .ifid_stall     (ifid_stall),
    .ifid_flush     (ifid_flush),
    .idex_bubble    (idex_bubble),
    .exmem_stall    (exmem_stall),
    .fwd_a          (fwd_a),
    .fwd_b          (fwd_b),
    .state          (state),
    .stall_cnt      (stall_cnt),
    .flush_cnt      (flush_cnt),
    .timeout_err    (timeout_err)
  );

  typedef struct packed {
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_use_rs1;
    logic       id_use_rs2;
    logic [4:0] ex_rd;
    logic       ex_rf_wr_en;
    logic       ex_is_load;
    logic [4:0] ex_rs1;
    logic [4:0] ex_rs2;
    logic       ex_branch_taken;
    logic [4:0] mem_rd;
    logic [4:0] wb_rd;
    logic       mem_rf_wr_en;
    logic       wb_rf_wr_en;
    logic       dmem_req;
    logic       dmem_ready;
  } in_t;

  typedef struct packed {
    logic pc;
    logic ifid_st;
    logic ifid_fl;
    logic bub;
    logic exm;
  } exp_t;

  // exp = {pc_stall, ifid_stall, ifid_flush, idex_bubble, exmem_stall, fwd_a, fwd_b}
  typedef struct {
    in_t        in;
    logic [8:0] exp;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  // Behavioural model: pipe frozen on memory, flush cycles left, raw event totals.
  bit m_waiting;
  int m_wait_run;
  int m_flush_left;
  int m_stalls;
  int m_flushes;
  bit m_timeout;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (cycle %0d): got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic drive(input in_t v);
    id_rs1          = v.id_rs1;
    id_rs2          = v.id_rs2;
    id_use_rs1      = v.id_use_rs1;
    id_use_rs2      = v.id_use_rs2;
    ex_rd           = v.ex_rd;
    ex_rf_wr_en     = v.ex_rf_wr_en;
    ex_is_load      = v.ex_is_load;
    ex_rs1          = v.ex_rs1;
    ex_rs2          = v.ex_rs2;
    ex_branch_taken = v.ex_branch_taken;
    mem_rd          = v.mem_rd;
    wb_rd           = v.wb_rd;
    mem_rf_wr_en    = v.mem_rf_wr_en;
    wb_rf_wr_en     = v.wb_rf_wr_en;
    dmem_req        = v.dmem_req;
    dmem_ready      = v.dmem_ready;
  endtask

  task automatic model_reset();
    m_waiting    = 1'b0;
    m_wait_run   = 0;
    m_flush_left = 0;
    m_stalls     = 0;
    m_flushes    = 0;
    m_timeout    = 1'b0;
  endtask

  function automatic int fwd_ref(input logic [4:0] rs, input in_t v);
    if (v.mem_rf_wr_en && v.mem_rd != 0 && v.mem_rd == rs) return 1;
    if (v.wb_rf_wr_en && v.wb_rd != 0 && v.wb_rd == rs) return 2;
    return 0;
  endfunction

  function automatic exp_t model_out(input in_t v);
    exp_t e;
    bit   mw, lu, hold;
    e  = '0;
    mw = v.dmem_req && !v.dmem_ready;
    lu = v.ex_is_load && v.ex_rf_wr_en && v.ex_rd != 0 &&
         ((v.id_use_rs1 && v.id_rs1 == v.ex_rd) || (v.id_use_rs2 && v.id_rs2 == v.ex_rd));
    hold = m_waiting ? !v.dmem_ready : mw;
    if (hold) begin
      e.pc = 1'b1; e.ifid_st = 1'b1; e.exm = 1'b1;
    end else if (m_waiting) begin
      e = '0;
    end else if (m_flush_left > 0) begin
      e.ifid_fl = 1'b1;
    end else if (v.ex_branch_taken) begin
      e.ifid_fl = 1'b1; e.bub = 1'b1;
    end else if (lu) begin
      e.pc = 1'b1; e.ifid_st = 1'b1; e.bub = 1'b1;
    end
    return e;
  endfunction

  task automatic model_update(input in_t v, input exp_t e);
    bit mw;
    mw = v.dmem_req && !v.dmem_ready;
    if (e.pc) m_stalls++;
    if (m_waiting) begin
      if (!v.dmem_ready) begin
        m_wait_run++;
        if (m_wait_run >= MEM_TIMEOUT) m_timeout = 1'b1;
      end else begin
        m_waiting  = 1'b0;
        m_wait_run = 0;
      end
    end else if (m_flush_left > 0) begin
      if (!mw) m_flush_left--;
    end else if (mw) begin
      m_waiting  = 1'b1;
      m_wait_run = 0;
    end else if (v.ex_branch_taken) begin
      m_flushes++;
      m_flush_left = FLUSH_LEN - 1;
    end
  endtask

  function automatic int sat(input int n);
    return (n > CNT_MAX) ? CNT_MAX : n;
  endfunction

  function automatic int exp_state();
    if (m_waiting) return 1;
    if (m_flush_left > 0) return 2;
    return 0;
  endfunction

  task automatic step(input in_t v);
    exp_t e;
    @(negedge clk);
    drive(v);
    #1;
    e = model_out(v);
    check("pc_stall",    32'(pc_stall),    32'(e.pc));
    check("ifid_stall",  32'(ifid_stall),  32'(e.ifid_st));
    check("ifid_flush",  32'(ifid_flush),  32'(e.ifid_fl));
    check("idex_bubble", 32'(idex_bubble), 32'(e.bub));
    check("exmem_stall", 32'(exmem_stall), 32'(e.exm));
    check("fwd_a",       32'(fwd_a),       32'(fwd_ref(v.ex_rs1, v)));
    check("fwd_b",       32'(fwd_b),       32'(fwd_ref(v.ex_rs2, v)));
    check("state",       32'(state),       32'(exp_state()));
    check("stall_cnt",   32'(stall_cnt),   32'(sat(m_stalls)));
    check("flush_cnt",   32'(flush_cnt),   32'(sat(m_flushes)));
    check("timeout_err", 32'(timeout_err), 32'(m_timeout));
    @(posedge clk);
    model_update(v, e);
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive('0);
    reset = 1'b0;
    #1;
    check("rst_state",     32'(state),       32'd0);
    check("rst_stall_cnt", 32'(stall_cnt),   32'd0);
    check("rst_flush_cnt", 32'(flush_cnt),   32'd0);
    check("rst_timeout",   32'(timeout_err), 32'd0);
    check("rst_pc_stall",  32'(pc_stall),    32'd0);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
  endtask

  task automatic add_vec(input in_t v, input logic [8:0] e);
    vec_t r;
    r.in  = v;
    r.exp = e;
    tbl.push_back(r);
  endtask

  function automatic in_t rnd_in(input int rdiv);
    in_t v;
    v.id_rs1          = 5'($urandom_range(0, 3));
    v.id_rs2          = 5'($urandom_range(0, 3));
    v.id_use_rs1      = 1'($urandom_range(0, 1));
    v.id_use_rs2      = 1'($urandom_range(0, 1));
    v.ex_rd           = 5'($urandom_range(0, 3));
    v.ex_rf_wr_en     = ($urandom_range(0, 3) != 0);
    v.ex_is_load      = 1'($urandom_range(0, 1));
    v.ex_rs1          = 5'($urandom_range(0, 3));
    v.ex_rs2          = 5'($urandom_range(0, 3));
    v.ex_branch_taken = ($urandom_range(0, 5) == 0);
    v.mem_rd          = 5'($urandom_range(0, 3));
    v.wb_rd           = 5'($urandom_range(0, 3));
    v.mem_rf_wr_en    = 1'($urandom_range(0, 1));
    v.wb_rf_wr_en     = 1'($urandom_range(0, 1));
    v.dmem_req        = ($urandom_range(0, 3) == 0);
    v.dmem_ready      = ($urandom_range(0, rdiv - 1) == 0);
    return v;
  endfunction

  initial begin
    in_t v, lu, mw, br, idle;
    logic [8:0] got;

    idle = '0;
    lu = '0;
    lu.ex_is_load = 1'b1; lu.ex_rf_wr_en = 1'b1; lu.ex_rd = 5'd5;
    lu.id_rs1 = 5'd5; lu.id_use_rs1 = 1'b1;
    mw = '0;
    mw.dmem_req = 1'b1;
    br = '0;
    br.ex_branch_taken = 1'b1;

    add_vec(idle, 9'b00000_00_00);
    add_vec(lu, 9'b11010_00_00);
    v = lu; v.ex_rd = 5'd0; v.id_rs1 = 5'd0;
    add_vec(v, 9'b00000_00_00);
    v = lu; v.ex_rd = 5'd7; v.id_rs2 = 5'd7; v.id_use_rs2 = 1'b1; v.id_rs1 = 5'd3;
    add_vec(v, 9'b11010_00_00);
    v = lu; v.id_use_rs1 = 1'b0;
    add_vec(v, 9'b00000_00_00);
    v = lu; v.ex_is_load = 1'b0;
    add_vec(v, 9'b00000_00_00);
    v = lu; v.ex_rf_wr_en = 1'b0;
    add_vec(v, 9'b00000_00_00);
    v = mw; v.dmem_ready = 1'b1;
    add_vec(v, 9'b00000_00_00);
    v = '0; v.ex_rs1 = 5'd3; v.mem_rd = 5'd3; v.wb_rd = 5'd3; v.mem_rf_wr_en = 1'b1; v.wb_rf_wr_en = 1'b1;
    add_vec(v, 9'b00000_01_00);
    v.mem_rf_wr_en = 1'b0;
    add_vec(v, 9'b00000_10_00);
    v = '0; v.mem_rf_wr_en = 1'b1; v.wb_rf_wr_en = 1'b1;
    add_vec(v, 9'b00000_00_00);
    v = '0; v.ex_rs1 = 5'd4; v.ex_rs2 = 5'd9; v.mem_rd = 5'd4; v.wb_rd = 5'd9;
    v.mem_rf_wr_en = 1'b1; v.wb_rf_wr_en = 1'b1;
    add_vec(v, 9'b00000_01_10);
    add_vec(br, 9'b00110_00_00);
    v = lu; v.ex_branch_taken = 1'b1;
    add_vec(v, 9'b00110_00_00);
    v.dmem_req = 1'b1;
    add_vec(v, 9'b11001_00_00);

    drive(idle);
    do_reset();

    // Fixed vectors, each applied and withdrawn between clock edges.
    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i].in);
      #1;
      got = {pc_stall, ifid_stall, ifid_flush, idex_bubble, exmem_stall, fwd_a, fwd_b};
      check($sformatf("vec%0d", i), 32'(got), 32'(tbl[i].exp));
      drive(idle);
    end

    // Single-cycle load-use stall; x0 destination never stalls.
    do_reset();
    step(lu);
    step(idle);
    check("lu_stall_cnt", 32'(stall_cnt), 32'd1);
    v = lu; v.ex_rd = 5'd0; v.id_rs1 = 5'd0;
    step(v);
    check("lu_x0_stall_cnt", 32'(stall_cnt), 32'd1);

    // Memory wait with ready low for 3 cycles.
    do_reset();
    step(mw);
    check("mw_state", 32'(state), 32'd1);
    step(mw);
    step(mw);
    v = mw; v.dmem_ready = 1'b1;
    step(v);
    step(idle);
    check("mw_stall_cnt", 32'(stall_cnt), 32'd3);
    check("mw_state_run", 32'(state), 32'd0);

    // Timeout after 16 ready-low cycles, sticky after ready.
    do_reset();
    repeat (15) step(mw);
    check("to_not_yet", 32'(timeout_err), 32'd0);
    step(mw);
    check("to_set", 32'(timeout_err), 32'd1);
    v = mw; v.dmem_ready = 1'b1;
    step(v);
    step(idle);
    check("to_sticky", 32'(timeout_err), 32'd1);

    // Branch flush over FLUSH_LEN cycles; branch ignored inside FLUSH.
    do_reset();
    step(br);
    check("br_state_flush", 32'(state), 32'd2);
    step(br);
    step(idle);
    check("br_flush_cnt", 32'(flush_cnt), 32'd1);
    check("br_state_run", 32'(state), 32'd0);

    // Branch coincident with load-use: flush only.
    do_reset();
    v = lu; v.ex_branch_taken = 1'b1;
    step(v);
    check("brlu_stall_cnt", 32'(stall_cnt), 32'd0);
    check("brlu_flush_cnt", 32'(flush_cnt), 32'd1);
    step(idle);

    // Branch held during MEM_WAIT is serviced in the first RUN cycle.
    do_reset();
    step(mw);
    v = mw; v.ex_branch_taken = 1'b1;
    step(v);
    v.dmem_ready = 1'b1;
    step(v);
    check("brmw_flush_cnt0", 32'(flush_cnt), 32'd0);
    step(br);
    check("brmw_flush_cnt1", 32'(flush_cnt), 32'd1);
    step(idle);
    step(idle);

    // Asynchronous reset in the middle of MEM_WAIT.
    do_reset();
    step(mw);
    step(mw);
    v = lu; v.dmem_req = 1'b1; v.ex_rs1 = 5'd3; v.mem_rd = 5'd3; v.mem_rf_wr_en = 1'b1;
    drive(v);
    #1;
    check("armw_pc_stall", 32'(pc_stall), 32'd1);
    check("armw_fwd_a",    32'(fwd_a),    32'd1);
    reset = 1'b0;
    #1;
    check("armw_state",       32'(state),       32'd0);
    check("armw_pc_stall0",   32'(pc_stall),    32'd0);
    check("armw_ifid_stall",  32'(ifid_stall),  32'd0);
    check("armw_exmem_stall", 32'(exmem_stall), 32'd0);
    check("armw_bubble",      32'(idex_bubble), 32'd0);
    check("armw_fwd_a0",      32'(fwd_a),       32'd0);
    check("armw_stall_cnt",   32'(stall_cnt),   32'd0);
    check("armw_timeout",     32'(timeout_err), 32'd0);
    @(negedge clk);
    drive(idle);
    reset = 1'b1;
    model_reset();
    step(idle);
    step(idle);

    // Stall counter saturation.
    do_reset();
    repeat (20) step(lu);
    check("sat_stall_cnt", 32'(stall_cnt), 32'd15);

    // Randomized traffic: mixed ready rates, periodic resets.
    for (int i = 0; i < 3000; i++) begin
      if (i % 500 == 0) do_reset();
      step(rnd_in((i < 1500) ? 2 : 12));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Hazard and stall sequencer for the 5-stage pipelined CPU. It watches the register addresses leaving the IF/ID and ID/EX registers, the EX-stage branch outcome and the data-memory handshake. From these it drives the per-stage stall, bubble and flush controls that gate the pipeline registers (IF/ID, ID/EX, EX/MEM), plus the EX-stage operand forwarding selects. It also keeps saturating stall/flush performance counters and flags data-memory timeouts.

## Interface
- FLUSH_LEN, 1: cycles IF/ID flush is held after a taken branch (1..4)
- MEM_TIMEOUT, 15: MEM_WAIT cycles before timeout_err sets
- CNT_W, 32: performance counter width
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-low
- id_rs1, id_rs2  in  5  source registers of the instruction in ID
- id_use_rs1, id_use_rs2  in  1  instruction in ID actually reads rs1/rs2
- ex_rd  in  5  destination register in EX (ID/EX output)
- ex_rf_wr_en  in  1  EX instruction writes the register file
- ex_is_load  in  1  EX instruction is a load (dm_rd_ctrl != 0)
- ex_rs1, ex_rs2  in  5  source registers of the EX instruction, for forwarding
- ex_branch_taken  in  1  jump/branch resolved taken in EX
- mem_rd, wb_rd  in  5  destination registers in MEM and WB
- mem_rf_wr_en, wb_rf_wr_en  in  1  write enables in MEM and WB
- dmem_req  in  1  MEM stage has an active data-memory access
- dmem_ready  in  1  data memory completes the access this cycle
- pc_stall  out  1  hold PC
- ifid_stall  out  1  hold IF/ID register
- ifid_flush  out  1  load NOP into IF/ID
- idex_bubble  out  1  load NOP (all control signals 0) into ID/EX
- exmem_stall  out  1  hold ID/EX and EX/MEM registers
- fwd_a, fwd_b  out  2  EX operand select: 00 regfile, 01 EX/MEM, 10 MEM/WB
- state  out  2  00 RUN, 01 MEM_WAIT, 10 FLUSH
- stall_cnt, flush_cnt  out  CNT_W  saturating event counters
- timeout_err  out  1  sticky memory-timeout flag

## Operation
- Reset values: state RUN; stall_cnt, flush_cnt, timeout_err, and the internal wait/flush counters are 0. All stall/flush outputs are combinationally 0 in RUN with idle inputs.
- Hazard priority, highest first:
  1. Memory wait
  2. Branch flush
  3. Load-use stall
- Memory wait:
  - In RUN, dmem_req=1 with dmem_ready=0: pc_stall=ifid_stall=exmem_stall=1 in that cycle, then next state MEM_WAIT.
  - MEM_WAIT: the same three outputs stay 1 while dmem_ready=0. On the dmem_ready=1 cycle all three outputs drop, and the next state is RUN.
  - The wait counter increments each MEM_WAIT cycle. When it reaches MEM_TIMEOUT, timeout_err sets and stays set until reset. State remains MEM_WAIT until ready.
- Branch flush:
  - In RUN with ex_branch_taken=1 and no memory wait: ifid_flush=1 and idex_bubble=1 that cycle, and flush_cnt increments.
  - If FLUSH_LEN>1, go to FLUSH. FLUSH holds ifid_flush=1 for FLUSH_LEN-1 more cycles, then returns to RUN.
  - ex_branch_taken is ignored in FLUSH.
- Load-use stall:
  - Condition, in RUN only, with no wait and no branch: ex_is_load & ex_rf_wr_en & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
  - Response: pc_stall=ifid_stall=idex_bubble=1 for exactly that cycle.
  - The inserted bubble clears ex_rf_wr_en, so there is no re-stall.
- Forwarding (combinational, every state), shown for fwd_a; fwd_b is identical using ex_rs2:
  - 01 if mem_rf_wr_en & mem_rd!=0 & mem_rd==ex_rs1.
  - Else 10 if wb_rf_wr_en & wb_rd!=0 & wb_rd==ex_rs1.
  - Else 00. MEM match takes priority over WB.
- Counters:
  - stall_cnt increments on every cycle with pc_stall=1.
  - flush_cnt increments once per accepted taken branch.
  - Both saturate at all-ones.

## Timing
- All stall/flush/forward outputs are combinational from state plus inputs, with zero-cycle latency. State, counters and timeout_err are registered on the rising clk edge.
- reset low mid-operation (any state): outputs clear immediately and asynchronously, and the FSM goes to RUN.
- A taken branch arriving during MEM_WAIT is frozen with the pipe. It is serviced in the first RUN cycle after ready.
- dmem_req & dmem_ready in the same RUN cycle means no stall.
- Load-use stall coincident with ex_branch_taken: flush only, no stall_cnt increment.
- Register x0 never triggers a stall or forward.

## Test plan
- Load-use: ex_is_load=1, ex_rd=5, ex_rf_wr_en=1, id_rs1=5, id_use_rs1=1 -> pc_stall/ifid_stall/idex_bubble=1 for one cycle, stall_cnt=1. Same with ex_rd=0 -> no stall.
- Memory wait: dmem_req=1 with dmem_ready low 3 cycles -> state 01 and pc_stall/ifid_stall/exmem_stall=1 for 3 cycles, 0 on the ready cycle, stall_cnt=3. Holding ready low 16 cycles -> timeout_err=1 and stays 1 after ready.
- Branch: ex_branch_taken=1 with FLUSH_LEN=2 -> ifid_flush=1 for 2 cycles, idex_bubble=1 for 1 cycle, flush_cnt=1. Branch plus simultaneous load-use -> no stall.
- Forwarding: ex_rs1=3, mem_rd=3, wb_rd=3, both write enables 1 -> fwd_a=01. Clearing mem_rf_wr_en -> 10. ex_rs2=0 with a matching rd=0 -> fwd_b=00.
- Reset mid-MEM_WAIT: reset low -> state 00, all outputs 0, counters 0 asynchronously. After release, idle inputs produce no stalls.
- Saturation: CNT_W=4, 20 consecutive load-use stalls -> stall_cnt holds at 15.
